usbdev_aon_wake_ctrl: RTL and testbench



---
 rtl/usbdev_aon_wake_ctrl.sv | 181 ++++++++++++++++++
 tb/tb_usbdev_aon_wake_ctrl.sv | 235 +++++++++++++++++++++++
 2 files changed

// File: rtl/usbdev_aon_wake_ctrl.sv
// usbdev_aon_wake_ctrl
// Always-on sequencer for the USB AON wake detector suspend handshake: arms the
// detector on request, monitors for wake, raises a power-manager wake request,
// captures the wake cause and hands control back to the IP through an ACK phase.
//
// Optional feature macro: USBDEV_AON_WAKE_CTRL_ARM_TIMEOUT_EN
//   defined   : ARM phase is bounded by ArmTimeoutCycles; arm_timeout_o is live
//   undefined : ARM waits indefinitely; arm_timeout_o is tied to 0
//
// Ports
//   clk_aon_i             AON clock
//   rst_aon_ni            async active-low reset
//   suspend_req_i         IP request for AON monitoring (synchronized level)
//   resume_ack_i          IP powered and ready to take control back
//   wake_detect_active_i  detector active status
//   wake_req_i            detector wake request
//   bus_not_idle_i, bus_reset_i, sense_lost_i   detector event flags
//   suspend_req_aon_o     suspend request to the detector (high in ARM)
//   wake_ack_aon_o        wake acknowledge to the detector (high in ACK)
//   pwr_wake_req_o        wake request to the power manager (high in WAKE)
//   wake_cause_o          captured {sense_lost, bus_reset, bus_not_idle}
//   wake_cause_valid_o    wake_cause_o holds a capture
//   arm_timeout_o         sticky: last arm attempt timed out
//   state_o               encoded FSM state (debug)

module usbdev_aon_wake_ctrl #(
   parameter int unsigned ArmTimeoutCycles = 16
) (
   input  logic       clk_aon_i,
   input  logic       rst_aon_ni,
   input  logic       suspend_req_i,
   input  logic       resume_ack_i,
   input  logic       wake_detect_active_i,
   input  logic       wake_req_i,
   input  logic       bus_not_idle_i,
   input  logic       bus_reset_i,
   input  logic       sense_lost_i,
   output logic       suspend_req_aon_o,
   output logic       wake_ack_aon_o,
   output logic       pwr_wake_req_o,
   output logic [2:0] wake_cause_o,
   output logic       wake_cause_valid_o,
   output logic       arm_timeout_o,
   output logic [2:0] state_o
);

   localparam int unsigned CntW = 8;

   if (ArmTimeoutCycles < 2 || ArmTimeoutCycles > 255) begin : g_bad_timeout
      $error("ArmTimeoutCycles must be in 2..255");
   end

   typedef enum logic [2:0] {
      StIdle    = 3'd0,
      StArm     = 3'd1,
      StMonitor = 3'd2,
      StWake    = 3'd3,
      StAck     = 3'd4
   } state_e;

   state_e state_q, state_d;
   logic   arm_start_c;
   logic   capture_c;
   logic   timeout_hit;

   // Arm timeout counter: cleared on arm, counts ARM cycles, saturates
`ifdef USBDEV_AON_WAKE_CTRL_ARM_TIMEOUT_EN
   localparam logic [CntW-1:0] ArmLimit = CntW'(ArmTimeoutCycles - 1);

   logic [CntW-1:0] arm_cnt_q;
   logic            arm_timeout_q;

   assign timeout_hit = (arm_cnt_q == ArmLimit);

   always_ff @(posedge clk_aon_i or negedge rst_aon_ni) begin
      if (!rst_aon_ni) begin
         arm_cnt_q     <= '0;
         arm_timeout_q <= 1'b0;
      end else if (arm_start_c) begin
         arm_cnt_q     <= '0;
         arm_timeout_q <= 1'b0;
      end else if (state_q == StArm) begin
         if (arm_cnt_q != {CntW{1'b1}}) begin
            arm_cnt_q <= arm_cnt_q + CntW'(1);
         end
         // active wins over a coincident timeout
         if (!wake_detect_active_i && timeout_hit) begin
            arm_timeout_q <= 1'b1;
         end
      end
   end

   assign arm_timeout_o = arm_timeout_q;
`else
   assign timeout_hit   = 1'b0;
   assign arm_timeout_o = 1'b0;
`endif

   // State register
   always_ff @(posedge clk_aon_i or negedge rst_aon_ni) begin
      if (!rst_aon_ni) begin
         state_q <= StIdle;
      end else begin
         state_q <= state_d;
      end
   end

   // Next-state logic and transition strobes
   always_comb begin
      state_d     = state_q;
      arm_start_c = 1'b0;
      capture_c   = 1'b0;
      case (state_q)
         StIdle: begin
            if (suspend_req_i) begin
               state_d     = StArm;
               arm_start_c = 1'b1;
            end
         end
         StArm: begin
            if (wake_detect_active_i) begin
               state_d = StMonitor;
            end else if (timeout_hit) begin
               state_d = StIdle;
            end else if (!suspend_req_i) begin
               state_d = StAck;
            end
         end
         StMonitor: begin
            if (wake_req_i) begin
               state_d   = StWake;
               capture_c = 1'b1;
            end else if (!suspend_req_i) begin
               state_d = StAck;
            end
         end
         StWake: begin
            if (resume_ack_i) begin
               state_d = StAck;
            end
         end
         StAck: begin
            // hold until the detector has dropped and the IP has released suspend
            if (!wake_detect_active_i && !suspend_req_i) begin
               state_d = StIdle;
            end
         end
         default: state_d = StIdle;
      endcase
   end

   // Handshake outputs registered from the next state so they track state_o exactly
   always_ff @(posedge clk_aon_i or negedge rst_aon_ni) begin
      if (!rst_aon_ni) begin
         suspend_req_aon_o <= 1'b0;
         wake_ack_aon_o    <= 1'b0;
         pwr_wake_req_o    <= 1'b0;
      end else begin
         suspend_req_aon_o <= (state_d == StArm);
         wake_ack_aon_o    <= (state_d == StAck);
         pwr_wake_req_o    <= (state_d == StWake);
      end
   end

   // Wake cause capture; held until the next arm
   always_ff @(posedge clk_aon_i or negedge rst_aon_ni) begin
      if (!rst_aon_ni) begin
         wake_cause_o       <= 3'b000;
         wake_cause_valid_o <= 1'b0;
      end else if (arm_start_c) begin
         wake_cause_o       <= 3'b000;
         wake_cause_valid_o <= 1'b0;
      end else if (capture_c) begin
         wake_cause_o       <= {sense_lost_i, bus_reset_i, bus_not_idle_i};
         wake_cause_valid_o <= 1'b1;
      end
   end

   assign state_o = state_q;

endmodule

// File: tb/tb_usbdev_aon_wake_ctrl.sv
// Testbench for usbdev_aon_wake_ctrl: directed handshake scenarios followed by
// randomized inputs, all checked against a cycle-level behavioural model.
module tb_usbdev_aon_wake_ctrl;

   localparam int N = 16;
`ifdef USBDEV_AON_WAKE_CTRL_ARM_TIMEOUT_EN
   localparam bit ToEn = 1'b1;
`else
   localparam bit ToEn = 1'b0;
`endif

   logic       clk_aon_i = 1'b0;
   logic       rst_aon_ni = 1'b1;
   logic       suspend_req_i = 1'b0;
   logic       resume_ack_i = 1'b0;
   logic       wake_detect_active_i = 1'b0;
   logic       wake_req_i = 1'b0;
   logic       bus_not_idle_i = 1'b0;
   logic       bus_reset_i = 1'b0;
   logic       sense_lost_i = 1'b0;
   logic       suspend_req_aon_o;
   logic       wake_ack_aon_o;
   logic       pwr_wake_req_o;
   logic [2:0] wake_cause_o;
   logic       wake_cause_valid_o;
   logic       arm_timeout_o;
   logic [2:0] state_o;

   int total = 0;
   int bad   = 0;

   // reference model: phase name as integer, number of cycles spent in ARM so far
   int         m_st;
   int         m_arm;
   logic [2:0] m_cause;
   logic       m_valid;
   logic       m_to;

   usbdev_aon_wake_ctrl #(.ArmTimeoutCycles(N)) dut (
      .clk_aon_i           (clk_aon_i),
      .rst_aon_ni          (rst_aon_ni),
      .suspend_req_i       (suspend_req_i),
      .resume_ack_i        (resume_ack_i),
      .wake_detect_active_i(wake_detect_active_i),
      .wake_req_i          (wake_req_i),
      .bus_not_idle_i      (bus_not_idle_i),
      .bus_reset_i         (bus_reset_i),
      .sense_lost_i        (sense_lost_i),
      .suspend_req_aon_o   (suspend_req_aon_o),
      .wake_ack_aon_o      (wake_ack_aon_o),
      .pwr_wake_req_o      (pwr_wake_req_o),
      .wake_cause_o        (wake_cause_o),
      .wake_cause_valid_o  (wake_cause_valid_o),
      .arm_timeout_o       (arm_timeout_o),
      .state_o             (state_o)
   );

   always #5 clk_aon_i = ~clk_aon_i;

   task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic m_reset();
      m_st = 0; m_arm = 0; m_cause = 3'b000; m_valid = 1'b0; m_to = 1'b0;
   endtask

   // advance the model by one clock using the inputs currently applied
   task automatic m_step();
      case (m_st)
         0: if (suspend_req_i) begin
               m_st = 1; m_arm = 0; m_cause = 3'b000; m_valid = 1'b0; m_to = 1'b0;
            end
         1: begin
               m_arm++;
               if (wake_detect_active_i) m_st = 2;
               else if (ToEn && m_arm == N) begin m_st = 0; m_to = 1'b1; end
               else if (!suspend_req_i) m_st = 4;
            end
         2: if (wake_req_i) begin
               m_st = 3; m_valid = 1'b1;
               m_cause = {sense_lost_i, bus_reset_i, bus_not_idle_i};
            end else if (!suspend_req_i) m_st = 4;
         3: if (resume_ack_i) m_st = 4;
         4: if (!wake_detect_active_i && !suspend_req_i) m_st = 0;
         default: m_st = 0;
      endcase
   endtask

   task automatic check_all(input string tag);
      chk({tag, ".state"}, 8'(state_o), 8'(m_st));
      chk({tag, ".susp"},  8'(suspend_req_aon_o), 8'(m_st == 1));
      chk({tag, ".pwr"},   8'(pwr_wake_req_o), 8'(m_st == 3));
      chk({tag, ".ack"},   8'(wake_ack_aon_o), 8'(m_st == 4));
      chk({tag, ".cause"}, 8'(wake_cause_o), 8'(m_cause));
      chk({tag, ".valid"}, 8'(wake_cause_valid_o), 8'(m_valid));
      chk({tag, ".to"},    8'(arm_timeout_o), 8'(m_to));
   endtask

   // one clock: model consumes current inputs, then DUT is sampled #1 after the edge
   task automatic tick(input string tag);
      m_step();
      @(posedge clk_aon_i);
      #1;
      check_all(tag);
   endtask

   initial begin
      // reset
      m_reset();
      #1 rst_aon_ni = 1'b0;
      repeat (2) @(posedge clk_aon_i);
      #1;
      check_all("rst");
      rst_aon_ni = 1'b1;
      tick("rst_idle");

      // full wake
      suspend_req_i = 1'b1;
      tick("full_arm");
      chk("full_arm_state", 8'(state_o), 8'd1);
      tick("full_arm2");
      wake_detect_active_i = 1'b1;
      tick("full_mon");
      chk("full_mon_state", 8'(state_o), 8'd2);
      wake_req_i = 1'b1; bus_not_idle_i = 1'b1;
      tick("full_wake");
      chk("full_wake_state", 8'(state_o), 8'd3);
      chk("full_cause", 8'(wake_cause_o), 8'h01);
      chk("full_pwr", 8'(pwr_wake_req_o), 8'd1);
      wake_req_i = 1'b0; bus_not_idle_i = 1'b0; resume_ack_i = 1'b1;
      tick("full_ack");
      chk("full_ack_state", 8'(state_o), 8'd4);
      chk("full_ack_pwr", 8'(pwr_wake_req_o), 8'd0);
      resume_ack_i = 1'b0; wake_detect_active_i = 1'b0; suspend_req_i = 1'b0;
      tick("full_idle");
      chk("full_idle_state", 8'(state_o), 8'd0);
      chk("full_hold_valid", 8'(wake_cause_valid_o), 8'd1);

      // abort in MONITOR; ACK holds while detector is still active
      suspend_req_i = 1'b1;
      tick("abort_arm");
      chk("abort_arm_valid", 8'(wake_cause_valid_o), 8'd0);
      wake_detect_active_i = 1'b1;
      tick("abort_mon");
      suspend_req_i = 1'b0;
      tick("abort_ack");
      chk("abort_ack", 8'(wake_ack_aon_o), 8'd1);
      tick("abort_ack_hold");
      chk("abort_ack_hold_state", 8'(state_o), 8'd4);
      wake_detect_active_i = 1'b0;
      tick("abort_idle");

      // wake_req beats the abort in MONITOR
      suspend_req_i = 1'b1;
      tick("sim_arm");
      wake_detect_active_i = 1'b1;
      tick("sim_mon");
      wake_req_i = 1'b1; suspend_req_i = 1'b0; sense_lost_i = 1'b1; bus_reset_i = 1'b1;
      tick("sim_wake");
      chk("sim_wake_state", 8'(state_o), 8'd3);
      chk("sim_cause", 8'(wake_cause_o), 8'h06);
      wake_req_i = 1'b0; sense_lost_i = 1'b0; bus_reset_i = 1'b0;
      tick("sim_wake_hold");

      // asynchronous reset while in WAKE
      #2 rst_aon_ni = 1'b0;
      #1;
      m_reset();
      check_all("rst_wake");
      chk("rst_wake_pwr", 8'(pwr_wake_req_o), 8'd0);
      #1 rst_aon_ni = 1'b1;
      wake_detect_active_i = 1'b0;
      tick("rst_wake_after");
      chk("rst_wake_state", 8'(state_o), 8'd0);

`ifdef USBDEV_AON_WAKE_CTRL_ARM_TIMEOUT_EN
      // arm timeout: IDLE N+1 cycles after the arm request, then re-arm
      suspend_req_i = 1'b1;
      for (int i = 1; i <= N + 1; i++) tick("to_run");
      chk("to_state", 8'(state_o), 8'd0);
      chk("to_flag", 8'(arm_timeout_o), 8'd1);
      tick("to_rearm");
      chk("to_rearm_state", 8'(state_o), 8'd1);
      chk("to_rearm_flag", 8'(arm_timeout_o), 8'd0);
      suspend_req_i = 1'b0;
      tick("to_abort");
      tick("to_idle");

      // active on the timeout cycle wins
      suspend_req_i = 1'b1;
      tick("tosim_arm");
      for (int i = 1; i < N; i++) tick("tosim_run");
      wake_detect_active_i = 1'b1;
      tick("tosim_mon");
      chk("tosim_state", 8'(state_o), 8'd2);
      chk("tosim_flag", 8'(arm_timeout_o), 8'd0);
      suspend_req_i = 1'b0;
      tick("tosim_ack");
      wake_detect_active_i = 1'b0;
      tick("tosim_idle");
`else
      // no timeout: ARM holds indefinitely
      suspend_req_i = 1'b1;
      for (int i = 0; i < 1000; i++) tick("noto_run");
      chk("noto_state", 8'(state_o), 8'd1);
      chk("noto_flag", 8'(arm_timeout_o), 8'd0);
      suspend_req_i = 1'b0;
      tick("noto_ack");
      tick("noto_idle");
`endif

      // randomized phase
      for (int i = 0; i < 3000; i++) begin
         if ($urandom_range(0, 7) == 0) suspend_req_i = ~suspend_req_i;
         // keep abort off the exact timeout cycle
         if (ToEn && m_st == 1 && m_arm == N - 1) suspend_req_i = 1'b1;
         wake_detect_active_i = ($urandom_range(0, 9) < ((m_st == 1) ? 1 : 6));
         wake_req_i           = ($urandom_range(0, 9) < 2);
         resume_ack_i         = ($urandom_range(0, 9) < 3);
         bus_not_idle_i       = 1'($urandom);
         bus_reset_i          = 1'($urandom);
         sense_lost_i         = 1'($urandom);
         tick("rand");
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
